// File: rtl/reaction_stats.sv
// Reaction-time statistics: count/min/max/last/sum plus a restoring-divide average, fouls counted apart.
// One result in flight plus a 1-deep pending slot; a result is processed SUM_W+2 edges after capture, overflow sets overrun.
module reaction_stats #(
  parameter int CNT_W = 4,
  parameter int SUM_W = 10 + CNT_W
) (
  input  logic             clk_50M,
  input  logic             clear,
  input  logic             res_valid,
  input  logic [9:0]       res_ms,
  input  logic             res_foul,
  input  logic [1:0]       disp_sel,
  output logic [9:0]       disp_ms,
  output logic [CNT_W-1:0] test_count,
  output logic [3:0]       foul_count,
  output logic [9:0]       min_ms,
  output logic [9:0]       max_ms,
  output logic [9:0]       avg_ms,
  output logic [9:0]       last_ms,
  output logic             avg_valid,
  output logic             busy,
  output logic             full,
  output logic             overrun
);

  localparam int MAX_TESTS = (1 << CNT_W) - 1;
  localparam int IT_W      = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DIV} state_t;

  state_t             state_q, state_d;
  logic               pend_vld_q, pend_vld_d;
  logic [9:0]         pend_ms_q, pend_ms_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         foul_q, foul_d;
  logic [9:0]         min_q, min_d, max_q, max_d, avg_q, avg_d, last_q, last_d, disp_q, disp_d;
  logic               avg_vld_q, avg_vld_d, ovr_q, ovr_d;
  logic [SUM_W-1:0]   sum_q, sum_d, quo_q, quo_d;
  logic [CNT_W-1:0]   rem_q, rem_d, dvs_q, dvs_d;
  logic [IT_W-1:0]    it_q, it_d;

  logic [9:0]         res_clamped;
  logic               is_full, fills, take;
  logic [CNT_W:0]     trial;
  logic [CNT_W-1:0]   diff;
  logic               qbit;
  logic [SUM_W-1:0]   sum_new, quo_nx;

  always_comb begin
    res_clamped = (res_ms > 10'd999) ? 10'd999 : res_ms;
    is_full     = (cnt_q == CNT_W'(MAX_TESTS));
    // The update in progress is about to make the table full; anything arriving now could never be stored.
    fills       = (state_q == S_UPDATE) && (cnt_q == CNT_W'(MAX_TESTS - 1));
    take        = res_valid && !res_foul && !is_full && !fills;
    trial       = {rem_q, quo_q[SUM_W-1]};
    qbit        = (trial >= {1'b0, dvs_q});
    diff        = trial[CNT_W-1:0] - dvs_q;
    sum_new     = sum_q + SUM_W'(pend_ms_q);
    quo_nx      = {quo_q[SUM_W-2:0], qbit};
  end

  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_ms_d  = pend_ms_q;
    cnt_d      = cnt_q;
    foul_d     = foul_q;
    min_d      = min_q;
    max_d      = max_q;
    avg_d      = avg_q;
    last_d     = last_q;
    avg_vld_d  = avg_vld_q;
    ovr_d      = ovr_q;
    sum_d      = sum_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    it_d       = it_q;
    disp_d     = disp_q;

    if (res_valid && res_foul && (foul_q != 4'hF)) foul_d = foul_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        last_d     = pend_ms_q;
        sum_d      = sum_new;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          min_d = pend_ms_q;
          max_d = pend_ms_q;
        end else begin
          if (pend_ms_q < min_q) min_d = pend_ms_q;
          if (pend_ms_q > max_q) max_d = pend_ms_q;
        end
        avg_vld_d  = 1'b0;
        pend_vld_d = 1'b0;
        quo_d      = sum_new;
        rem_d      = '0;
        dvs_d      = cnt_q + 1'b1;
        it_d       = '0;
        state_d    = S_DIV;
      end
      S_DIV: begin
        quo_d = quo_nx;
        rem_d = qbit ? diff : trial[CNT_W-1:0];
        it_d  = it_q + 1'b1;
        if (it_q == IT_W'(SUM_W - 1)) begin
          avg_d     = quo_nx[9:0];
          avg_vld_d = 1'b1;
          state_d   = pend_vld_q ? S_UPDATE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Evaluated after the FSM so a capture wins over the slot being freed in the same cycle.
    if (take) begin
      if (!pend_vld_q || (state_q == S_UPDATE)) begin
        pend_vld_d = 1'b1;
        pend_ms_d  = res_clamped;
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (disp_sel)
      2'b00:   disp_d = last_q;
      2'b01:   disp_d = min_q;
      2'b10:   disp_d = max_q;
      default: disp_d = avg_q;
    endcase
  end

  always_ff @(posedge clk_50M or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      pend_vld_q <= 1'b0;
      pend_ms_q  <= '0;
      cnt_q      <= '0;
      foul_q     <= '0;
      min_q      <= '0;
      max_q      <= '0;
      avg_q      <= '0;
      last_q     <= '0;
      avg_vld_q  <= 1'b0;
      ovr_q      <= 1'b0;
      sum_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      it_q       <= '0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_ms_q  <= pend_ms_d;
      cnt_q      <= cnt_d;
      foul_q     <= foul_d;
      min_q      <= min_d;
      max_q      <= max_d;
      avg_q      <= avg_d;
      last_q     <= last_d;
      avg_vld_q  <= avg_vld_d;
      ovr_q      <= ovr_d;
      sum_q      <= sum_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      it_q       <= it_d;
      disp_q     <= disp_d;
    end
  end

  assign disp_ms    = disp_q;
  assign test_count = cnt_q;
  assign foul_count = foul_q;
  assign min_ms     = min_q;
  assign max_ms     = max_q;
  assign avg_ms     = avg_q;
  assign last_ms    = last_q;
  assign avg_valid  = avg_vld_q;
  assign busy       = (state_q != S_IDLE) || pend_vld_q;
  assign full       = is_full;
  assign overrun    = ovr_q;

endmodule
